code_mem_loader: RTL and testbench

//  Bus initiator that fills the code memory bank from a byte stream (boot/debug loader).

---
 rtl/code_mem_loader.sv | 163 ++++++++++++++++
 tb/tb_code_mem_loader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_mem_loader.sv
// Byte-stream boot/debug loader: packs bytes little-endian into 32-bit words
// and writes them into the code memory bank, one strobe per word.
module code_mem_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned WORD_LIMIT = 4096,
    parameter int unsigned COUNT_W    = 13
) (
    input  logic               iCLK,
    input  logic               iRST_n,
    input  logic               iStart,
    input  logic               iFlush,
    input  logic               iByteValid,
    input  logic [7:0]         iByteData,
    output logic               oByteReady,
    output logic [31:0]        oAddress,
    output logic [3:0]         oByteEnable,
    output logic [31:0]        oWriteData,
    output logic               oMemWrite,
    output logic               oMemRead,
    output logic               oBusy,
    output logic               oDone,
    output logic               oOverflow,
    output logic [COUNT_W-1:0] oWordCount
);

    localparam logic [31:0] BASE_ALIGNED = {BASE_ADDR[31:2], 2'b00};

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [1:0]           r_lane;
    logic [31:0]          r_addr;
    logic [31:0]          r_data;
    logic [3:0]           r_be;
    logic [COUNT_W-1:0]   r_count;
    logic                 r_done;
    logic                 r_ovf;
    logic                 r_flush;

    logic                 w_accept;
    logic [2:0]           w_fill;
    logic [COUNT_W-1:0]   w_count_inc;
    logic                 w_limit_hit;
    logic [3:0]           w_be;

    assign w_accept    = (r_state == S_COLLECT) && iByteValid;
    // lanes filled once this cycle's byte (if any) is counted; flush sees it
    assign w_fill      = {1'b0, r_lane} + {2'b00, w_accept};
    assign w_count_inc = r_count + COUNT_W'(1);
    assign w_limit_hit = (w_count_inc == COUNT_W'(WORD_LIMIT));

    always_comb begin
        w_be = 4'b1111;
        case (w_fill)
            3'd1:    w_be = 4'b0001;
            3'd2:    w_be = 4'b0011;
            3'd3:    w_be = 4'b0111;
            default: w_be = 4'b1111;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (iStart)
                    w_next = S_COLLECT;
            end
            S_COLLECT: begin
                if (w_fill == 3'd4 || (iFlush && w_fill != 3'd0))
                    w_next = S_WRITE;
                else if (iFlush)
                    w_next = S_DONE;
            end
            S_WRITE: begin
                if (w_limit_hit || r_flush)
                    w_next = S_DONE;
                else
                    w_next = S_COLLECT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_lane  <= '0;
            r_addr  <= BASE_ALIGNED;
            r_data  <= '0;
            r_be    <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_flush <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (iStart) begin
                        r_lane  <= '0;
                        r_addr  <= BASE_ALIGNED;
                        r_data  <= '0;
                        r_be    <= '0;
                        r_count <= '0;
                        r_done  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_flush <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        r_data[8*r_lane +: 8] <= iByteData;
                        r_lane                <= r_lane + 2'd1;
                    end
                    if (w_next == S_WRITE) begin
                        r_be    <= w_be;
                        r_flush <= iFlush;
                    end else if (w_next == S_DONE) begin
                        r_done <= 1'b1;
                    end
                end
                S_WRITE: begin
                    r_count <= w_count_inc;
                    r_addr  <= r_addr + 32'd4;
                    r_lane  <= '0;
                    r_data  <= '0;
                    r_be    <= '0;
                    r_flush <= 1'b0;
                    if (w_next == S_DONE) begin
                        r_done <= 1'b1;
                        r_ovf  <= w_limit_hit;
                    end
                end
                default: ;
            endcase
        end
    end

    // strobe decoded from state so an async reset drops it immediately
    assign oMemWrite   = (r_state == S_WRITE);
    assign oByteReady  = (r_state == S_COLLECT);
    assign oBusy       = (r_state == S_COLLECT) || (r_state == S_WRITE);
    assign oMemRead    = 1'b0;
    assign oAddress    = r_addr;
    assign oByteEnable = r_be;
    assign oWriteData  = r_data;
    assign oDone       = r_done;
    assign oOverflow   = r_ovf;
    assign oWordCount  = r_count;

endmodule

// File: tb/tb_code_mem_loader.sv
// Directed/table-driven bench for code_mem_loader: default instance plus a
// WORD_LIMIT=2 instance for the overflow case.
module tb_code_mem_loader;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic        i_flush;
    logic        i_valid;
    logic [7:0]  i_byte;

    logic        r0_ready, r0_mw, r0_mr, r0_busy, r0_done, r0_ovf;
    logic [31:0] r0_addr, r0_wdata;
    logic [3:0]  r0_be;
    logic [12:0] r0_count;

    logic        r1_ready, r1_mw, r1_mr, r1_busy, r1_done, r1_ovf;
    logic [31:0] r1_addr, r1_wdata;
    logic [3:0]  r1_be;
    logic [12:0] r1_count;

    int n_checks = 0;
    int n_errors = 0;

    code_mem_loader #(.BASE_ADDR(32'h0), .WORD_LIMIT(4096), .COUNT_W(13)) dut0 (
        .iCLK(clk), .iRST_n(rst_n), .iStart(i_start), .iFlush(i_flush),
        .iByteValid(i_valid), .iByteData(i_byte), .oByteReady(r0_ready),
        .oAddress(r0_addr), .oByteEnable(r0_be), .oWriteData(r0_wdata),
        .oMemWrite(r0_mw), .oMemRead(r0_mr), .oBusy(r0_busy), .oDone(r0_done),
        .oOverflow(r0_ovf), .oWordCount(r0_count)
    );

    code_mem_loader #(.BASE_ADDR(32'h0), .WORD_LIMIT(2), .COUNT_W(13)) dut1 (
        .iCLK(clk), .iRST_n(rst_n), .iStart(i_start), .iFlush(i_flush),
        .iByteValid(i_valid), .iByteData(i_byte), .oByteReady(r1_ready),
        .oAddress(r1_addr), .oByteEnable(r1_be), .oWriteData(r1_wdata),
        .oMemWrite(r1_mw), .oMemRead(r1_mr), .oBusy(r1_busy), .oDone(r1_done),
        .oOverflow(r1_ovf), .oWordCount(r1_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        flush;
        logic        valid;
        logic [7:0]  data;
        logic        e_ready;
        logic        e_mw;
        logic        e_busy;
        logic        e_done;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        int          e_count;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic st, input logic fl, input logic va, input logic [7:0] d,
                       input logic rdy, input logic mw, input logic bsy, input logic dn,
                       input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                       input int cnt);
        vec_t v;
        v.start = st; v.flush = fl; v.valid = va; v.data = d;
        v.e_ready = rdy; v.e_mw = mw; v.e_busy = bsy; v.e_done = dn;
        v.e_addr = a; v.e_wdata = wd; v.e_be = be; v.e_count = cnt;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        i_start = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_byte = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_mw"},    {31'd0, r0_mw},    32'd0);
        check({tag, "_ready"}, {31'd0, r0_ready}, 32'd0);
        check({tag, "_busy"},  {31'd0, r0_busy},  32'd0);
        check({tag, "_done"},  {31'd0, r0_done},  32'd0);
        check({tag, "_ovf"},   {31'd0, r0_ovf},   32'd0);
        check({tag, "_addr"},  r0_addr,           32'h0);
        check({tag, "_be"},    {28'd0, r0_be},    32'd0);
        check({tag, "_wdata"}, r0_wdata,          32'h0);
        check({tag, "_count"}, {19'd0, r0_count}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #2;
        check_reset_state("reset");
        check("reset_memread", {31'd0, r0_mr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // st fl va data   rdy mw bsy dn  addr   wdata         be      cnt
        add(1, 0, 0, 8'h00, 0, 0, 0, 0, 32'h0, 32'h0,        4'h0, 0);
        add(0, 0, 1, 8'h11, 1, 0, 1, 0, 32'h0, 32'h0,        4'h0, 0);
        add(0, 0, 1, 8'h22, 1, 0, 1, 0, 32'h0, 32'h0,        4'h0, 0);
        add(0, 0, 1, 8'h33, 1, 0, 1, 0, 32'h0, 32'h0,        4'h0, 0);
        add(0, 0, 1, 8'h44, 1, 0, 1, 0, 32'h0, 32'h0,        4'h0, 0);
        add(0, 0, 1, 8'h55, 0, 1, 1, 0, 32'h0, 32'h44332211, 4'hF, 0);
        add(0, 0, 1, 8'h55, 1, 0, 1, 0, 32'h0, 32'h0,        4'h0, 1);
        add(1, 0, 1, 8'h66, 1, 0, 1, 0, 32'h0, 32'h0,        4'h0, 1);
        add(0, 0, 1, 8'h77, 1, 0, 1, 0, 32'h0, 32'h0,        4'h0, 1);
        add(0, 0, 1, 8'h88, 1, 0, 1, 0, 32'h0, 32'h0,        4'h0, 1);
        add(0, 0, 0, 8'h00, 0, 1, 1, 0, 32'h4, 32'h88776655, 4'hF, 1);
        add(0, 0, 0, 8'h00, 1, 0, 1, 0, 32'h0, 32'h0,        4'h0, 2);
        add(0, 1, 0, 8'h00, 1, 0, 1, 0, 32'h0, 32'h0,        4'h0, 2);
        add(0, 0, 0, 8'h00, 0, 0, 0, 1, 32'h0, 32'h0,        4'h0, 2);
        add(1, 0, 0, 8'h00, 0, 0, 0, 1, 32'h0, 32'h0,        4'h0, 2);
        add(0, 0, 1, 8'hAA, 1, 0, 1, 0, 32'h0, 32'h0,        4'h0, 0);
        add(0, 0, 1, 8'hBB, 1, 0, 1, 0, 32'h0, 32'h0,        4'h0, 0);
        add(0, 0, 1, 8'hCC, 1, 0, 1, 0, 32'h0, 32'h0,        4'h0, 0);
        add(0, 1, 0, 8'h00, 1, 0, 1, 0, 32'h0, 32'h0,        4'h0, 0);
        add(0, 0, 0, 8'h00, 0, 1, 1, 0, 32'h0, 32'h00CCBBAA, 4'h7, 0);
        add(0, 0, 0, 8'h00, 0, 0, 0, 1, 32'h0, 32'h0,        4'h0, 1);
        add(1, 0, 0, 8'h00, 0, 0, 0, 1, 32'h0, 32'h0,        4'h0, 1);
        add(0, 1, 1, 8'h5A, 1, 0, 1, 0, 32'h0, 32'h0,        4'h0, 0);
        add(0, 0, 0, 8'h00, 0, 1, 1, 0, 32'h0, 32'h0000005A, 4'h1, 0);
        add(0, 0, 1, 8'h77, 0, 0, 0, 1, 32'h0, 32'h0,        4'h0, 1);
        add(1, 0, 0, 8'h00, 0, 0, 0, 1, 32'h0, 32'h0,        4'h0, 1);
        add(0, 1, 0, 8'h00, 1, 0, 1, 0, 32'h0, 32'h0,        4'h0, 0);
        add(0, 0, 0, 8'h00, 0, 0, 0, 1, 32'h0, 32'h0,        4'h0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            i_start = vecs[i].start;
            i_flush = vecs[i].flush;
            i_valid = vecs[i].valid;
            i_byte  = vecs[i].data;
            #1;
            check($sformatf("v%0d_ready", i), {31'd0, r0_ready}, {31'd0, vecs[i].e_ready});
            check($sformatf("v%0d_mw", i),    {31'd0, r0_mw},    {31'd0, vecs[i].e_mw});
            check($sformatf("v%0d_busy", i),  {31'd0, r0_busy},  {31'd0, vecs[i].e_busy});
            check($sformatf("v%0d_done", i),  {31'd0, r0_done},  {31'd0, vecs[i].e_done});
            check($sformatf("v%0d_ovf", i),   {31'd0, r0_ovf},   32'd0);
            check($sformatf("v%0d_count", i), {19'd0, r0_count}, 32'(vecs[i].e_count));
            if (vecs[i].e_mw) begin
                check($sformatf("v%0d_addr", i),  r0_addr,          vecs[i].e_addr);
                check($sformatf("v%0d_wdata", i), r0_wdata,         vecs[i].e_wdata);
                check($sformatf("v%0d_be", i),    {28'd0, r0_be},   {28'd0, vecs[i].e_be});
            end
        end

        // WORD_LIMIT=2 instance: 12 bytes offered, only 8 may be taken
        do_reset();
        begin
            int sent = 0;
            int writes = 0;
            @(negedge clk);
            i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
            for (int c = 0; c < 40 && !r1_done; c++) begin
                i_valid = (sent < 12);
                i_byte  = 8'(sent + 1);
                #1;
                if (r1_mw) begin
                    check("ovf_waddr", r1_addr, 32'(writes * 4));
                    check("ovf_wdata", r1_wdata,
                          (writes == 0) ? 32'h04030201 : 32'h08070605);
                    writes++;
                end
                if (i_valid && r1_ready)
                    sent++;
                @(negedge clk);
            end
            check("ovf_reached_done", {31'd0, r1_done}, 32'd1);
            check("ovf_writes",  32'(writes), 32'd2);
            check("ovf_accepted", 32'(sent), 32'd8);
            check("ovf_flag",    {31'd0, r1_ovf},   32'd1);
            check("ovf_count",   {19'd0, r1_count}, 32'd2);
            repeat (3) @(negedge clk);
            #1;
            check("ovf_ready_low", {31'd0, r1_ready}, 32'd0);
            check("ovf_mw_low",    {31'd0, r1_mw},    32'd0);
        end

        // reset asserted while the second word is being strobed
        do_reset();
        begin
            bit hit = 0;
            @(negedge clk);
            i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
            for (int k = 0; k < 8; k++) begin
                i_valid = 1'b1;
                i_byte  = 8'(8'hC0 + k);
                #1;
                if (!r0_ready) begin
                    @(negedge clk);
                    #1;
                end
                @(negedge clk);
            end
            i_valid = 1'b0;
            for (int c = 0; c < 4 && !hit; c++) begin
                #1;
                if (r0_mw) begin
                    check("rst_pre_addr", r0_addr, 32'h4);
                    rst_n = 1'b0;
                    #1;
                    hit = 1;
                    check_reset_state("rstmid");
                end else begin
                    @(negedge clk);
                end
            end
            check("rst_mid_write_seen", 32'(hit), 32'd1);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
            i_valid = 1'b1;
            i_byte = 8'h01; @(negedge clk);
            i_byte = 8'h02; @(negedge clk);
            i_byte = 8'h03; @(negedge clk);
            i_byte = 8'h04; @(negedge clk);
            i_valid = 1'b0;
            #1;
            check("rst_restart_mw",    {31'd0, r0_mw}, 32'd1);
            check("rst_restart_addr",  r0_addr,        32'h0);
            check("rst_restart_wdata", r0_wdata,       32'h04030201);
        end

        // random valid, 400 bytes, start pulses mid-session
        do_reset();
        begin
            logic [7:0] model[$];
            int accepted = 0;
            int writes = 0;
            int cyc = 0;
            logic [31:0] exp_word;
            @(negedge clk);
            i_start = 1'b1;
            @(negedge clk);
            while (writes < 100 && cyc < 5000) begin
                i_start = ($urandom_range(0, 15) == 0);
                i_valid = (accepted < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
                i_byte  = 8'($urandom);
                #1;
                if (r0_mw) begin
                    exp_word = {model[4*writes+3], model[4*writes+2],
                                model[4*writes+1], model[4*writes]};
                    check($sformatf("rnd_addr%0d", writes),  r0_addr,        32'(writes * 4));
                    check($sformatf("rnd_wdata%0d", writes), r0_wdata,       exp_word);
                    check($sformatf("rnd_be%0d", writes),    {28'd0, r0_be}, 32'hF);
                    writes++;
                end
                if (i_valid && r0_ready) begin
                    model.push_back(i_byte);
                    accepted++;
                end
                cyc++;
                @(negedge clk);
            end
            idle_inputs();
            check("rnd_writes", 32'(writes), 32'd100);
            @(negedge clk);
            i_flush = 1'b1;
            @(negedge clk);
            i_flush = 1'b0;
            #1;
            check("rnd_done",  {31'd0, r0_done},  32'd1);
            check("rnd_count", {19'd0, r0_count}, 32'd100);
            check("rnd_ovf",   {31'd0, r0_ovf},   32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
